uart_mmio_ctrl: RTL and testbench
=================================

# uart_mmio_ctrl

Memory-mapped UART transmit controller occupying the 1 KB MMIO window at 0x1000_0000 on the CPU data-memory port. Decodes CPU store/load cycles into four control/status registers, buffers outgoing bytes in a TX FIFO and serialises them as 8N1 frames on `tx` with a programmable bit period. Replaces the simulation-only character print with synthesisable hardware and gives software a status register to poll.

## Interface
- `BASE_ADDR`, 32'h1000_0000, MMIO window base; decode is `Addr[31:10] == BASE_ADDR[31:10]`.
- `FIFO_DEPTH`, 16, TX FIFO entries; power of two, at least 2.
- `DIV_RESET`, 16'd868, reset value of the bit-period register, in clk cycles.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low (0 = reset).
- `MemWrite` in 1: store strobe, one cycle per store.
- `MemRead` in 1: load strobe.
- `Addr` in 32: byte address.
- `WriteData` in 32: store data; low bits used.
- `funct3` in 3: access size; ignored, all accesses are treated as word-wide.
- `ReadData` out 32: registered load data.
- `tx` out 1: serial line, idles high.
- `irq` out 1: level interrupt.

## Operation
- Register select: `Addr[3:2]` within a decoded window. `Addr[9:4]` aliases.
- 0x0 TXDATA: a write pushes `WriteData[7:0]`. A read returns 0.
- 0x4 STATUS: read-only, except W1C on bit 3.
  - bit0 full, bit1 empty, bit2 busy (FSM not IDLE), bit3 overflow (sticky).
  - bits[8+CW-1:8] = FIFO count, where CW = log2(FIFO_DEPTH)+1.
- 0x8 DIV: bits[15:0] are the bit period. A written value of 0 is stored as 1. A new value takes effect at the next frame start.
- 0xC CTRL: bit0 enable, bit1 irq_en. All other bits read 0.
- Push when full: byte dropped and overflow set, except when a pop happens in the same cycle (see below).
- FSM states: IDLE, START, DATA, STOP. A bit counter (0-7) and a 16-bit cycle counter drive the sequencing.
- IDLE → START: when enable=1 and FIFO is non-empty. Pop the head into the shift register, latch DIV into the active-period register, set `tx`=0.
- START → DATA: after `period` cycles. Output data bits LSB first, each for `period` cycles.
- DATA → STOP: after bit 7. Hold `tx`=1 for `period` cycles.
- STOP exit: go to START if enable=1 and FIFO is non-empty (pop in that cycle), else go to IDLE.
- Clearing enable mid-frame does not abort: the current frame completes, then the FSM idles.
- Simultaneous push and pop:
  - FIFO full: both happen and the count is unchanged.
  - FIFO empty: no pop occurs, because the pop condition is evaluated on the pre-edge count.
- `irq` = irq_en & empty & ~busy, registered.
- Non-decoded addresses: writes ignored. A load returns 0.

## Timing
- Reset values:
  - `tx`=1, `ReadData`=0, `irq`=0.
  - FIFO pointers 0 (empty), overflow 0.
  - DIV=DIV_RESET, CTRL=0, FSM in IDLE.
- Reset asserted mid-frame: `tx` goes high immediately (asynchronous) and FIFO contents are discarded.
- Load latency: one cycle. `ReadData` is updated at the edge where `MemRead` is sampled and holds until the next load.
- A STATUS read reflects state before that edge's push/pop.
- Push is visible in STATUS one cycle after the store.
- First start bit: `tx` falls on the edge after the first push when the FIFO was empty, enable=1 and FSM is IDLE. That is, the store at cycle N gives `tx`=0 from edge N+1.
- Frame length: exactly 10·period cycles. Back-to-back frames have no idle gap.
- Counters wrap only by design. FIFO pointers are log2(FIFO_DEPTH) bits and wrap. The count saturates logically through the full/empty checks.

## Test plan
- Reset: hold `reset`=0 for 3 cycles with `MemWrite` toggling. Expect `tx`=1, STATUS=0x0000_0002, DIV=868, CTRL=0 and no FIFO change.
- Single frame: DIV=4, CTRL=1, write 0x55 to TXDATA.
  - Expect `tx` low for 4 cycles, then bits 1,0,1,0,1,0,1,0 at 4 cycles each, then high for 4 cycles: 40 cycles total.
  - busy drops on the 41st cycle.
- Overflow: CTRL=0, write 17 bytes.
  - Expect STATUS count=16, full=1, overflow=1.
  - Write 0x8 to STATUS and expect overflow=0 with count still 16.
- Back-to-back: DIV=2, enable, push 0x00 then 0xFF. Expect the second start bit immediately after the first stop bit, 40 cycles total, no gap.
- Mid-frame control: change DIV to 8 and clear enable during the first of two frames (DIV=3).
  - Expect frame 1 to finish at period 3 and frame 2 not to start.
  - Re-enable: expect frame 2 at period 8.
- Interrupt: CTRL=3 with the FIFO empty and idle gives `irq`=1. A push drops `irq` on the next cycle, and it reasserts one cycle after the final stop bit.

Source files
------------

// File: rtl/uart_mmio_ctrl_if.sv
// ---------------------------------------------------------------------------
// uart_mmio_ctrl_if
// CPU data-memory port bundle seen by the UART MMIO controller.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface uart_mmio_ctrl_if;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic [2:0]  funct3;
  logic [31:0] ReadData;

  modport master (
    output MemWrite, MemRead, Addr, WriteData, funct3,
    input  ReadData
  );

  modport slave (
    input  MemWrite, MemRead, Addr, WriteData, funct3,
    output ReadData
  );
endinterface

`default_nettype wire

// File: rtl/uart_mmio_ctrl.sv
// ---------------------------------------------------------------------------
// uart_mmio_ctrl
// MMIO UART transmitter: TXDATA/STATUS/DIV/CTRL registers, TX FIFO and an
// 8N1 serialiser with a programmable bit period.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module uart_mmio_ctrl #(
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [15:0] DIV_RESET  = 16'd868
) (
  input  logic             clk,
  input  logic             reset,
  uart_mmio_ctrl_if.slave  bus,
  output logic             tx,
  output logic             irq
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          overflow;
  logic          enable;
  logic          irq_en;
  logic [15:0]   div;
  logic [15:0]   period;
  logic [15:0]   cyc_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;

  logic          sel;
  logic [1:0]    reg_sel;
  logic          full;
  logic          empty;
  logic          busy;
  logic          bit_done;
  logic          pop;
  logic          push_req;
  logic          push;
  logic          wr_status;
  logic [31:0]   status_val;
  logic [31:0]   rd_val;
  logic          unused_bits;

  assign sel       = (bus.Addr[31:10] == BASE_ADDR[31:10]);
  assign reg_sel   = bus.Addr[3:2];
  assign full      = (count == CW'(FIFO_DEPTH));
  assign empty     = (count == '0);
  assign busy      = (state != IDLE);
  assign bit_done  = (cyc_cnt == period - 16'd1);
  // A frame may start from IDLE or straight out of the last stop-bit cycle;
  // using the pre-edge count means a push into an empty FIFO is never popped
  // in the same cycle.
  assign pop       = enable & ~empty & ((state == IDLE) | ((state == STOP) & bit_done));
  assign push_req  = bus.MemWrite & sel & (reg_sel == 2'd0);
  // When full, a concurrent pop frees the slot so the byte is still accepted.
  assign push      = push_req & (~full | pop);
  assign wr_status = bus.MemWrite & sel & (reg_sel == 2'd1);

  // Access size, upper data bits and aliasing address bits carry no meaning.
  assign unused_bits = ^{bus.funct3, bus.WriteData[31:16], bus.Addr[9:4], bus.Addr[1:0]};

  // Assemble the status word and the load-data mux.
  always_comb begin
    status_val          = '0;
    status_val[0]       = full;
    status_val[1]       = empty;
    status_val[2]       = busy;
    status_val[3]       = overflow;
    status_val[8 +: CW] = count;
    rd_val              = '0;
    if (sel) begin
      case (reg_sel)
        2'd1:    rd_val = status_val;
        2'd2:    rd_val = {16'd0, div};
        2'd3:    rd_val = {30'd0, irq_en, enable};
        default: rd_val = '0;
      endcase
    end
  end

  // FIFO storage; contents are discarded by resetting the pointers only.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= bus.WriteData[7:0];
  end

  // Register file, FIFO pointers/count, load data and interrupt.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      overflow     <= 1'b0;
      enable       <= 1'b0;
      irq_en       <= 1'b0;
      div          <= DIV_RESET;
      bus.ReadData <= '0;
      irq          <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (push_req & full & ~pop)
        overflow <= 1'b1;
      else if (wr_status & bus.WriteData[3])
        overflow <= 1'b0;
      if (bus.MemWrite & sel & (reg_sel == 2'd2))
        div <= (bus.WriteData[15:0] == 16'd0) ? 16'd1 : bus.WriteData[15:0];
      if (bus.MemWrite & sel & (reg_sel == 2'd3)) begin
        enable <= bus.WriteData[0];
        irq_en <= bus.WriteData[1];
      end
      if (bus.MemRead) bus.ReadData <= rd_val;
      irq <= irq_en & empty & ~busy;
    end
  end

  // Frame sequencer: start bit, eight data bits LSB first, stop bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      tx      <= 1'b1;
      cyc_cnt <= '0;
      bit_cnt <= '0;
      shift   <= '0;
      period  <= DIV_RESET;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            shift   <= fifo_mem[rd_ptr];
            period  <= div;
            cyc_cnt <= '0;
            tx      <= 1'b0;
            state   <= START;
          end
        end
        START: begin
          if (bit_done) begin
            cyc_cnt <= '0;
            bit_cnt <= '0;
            tx      <= shift[0];
            state   <= DATA;
          end else begin
            cyc_cnt <= cyc_cnt + 16'd1;
          end
        end
        DATA: begin
          if (bit_done) begin
            cyc_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              shift   <= shift >> 1;
              tx      <= shift[1];
            end
          end else begin
            cyc_cnt <= cyc_cnt + 16'd1;
          end
        end
        STOP: begin
          if (bit_done) begin
            cyc_cnt <= '0;
            if (pop) begin
              shift  <= fifo_mem[rd_ptr];
              period <= div;
              tx     <= 1'b0;
              state  <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            cyc_cnt <= cyc_cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_uart_mmio_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_mmio_ctrl
// Self-checking bench for uart_mmio_ctrl: register vectors plus serial
// frame sequences checked against a per-cycle expected tx queue.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_uart_mmio_ctrl;
  localparam logic [31:0] A_TX   = 32'h1000_0000;
  localparam logic [31:0] A_ST   = 32'h1000_0004;
  localparam logic [31:0] A_DIV  = 32'h1000_0008;
  localparam logic [31:0] A_CTRL = 32'h1000_000C;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic tx;
  logic irq;

  uart_mmio_ctrl_if bus ();

  uart_mmio_ctrl #(
    .BASE_ADDR (32'h1000_0000),
    .FIFO_DEPTH(16),
    .DIV_RESET (16'd868)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus),
    .tx   (tx),
    .irq  (irq)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] rd_q[$];
  logic        tx_q[$];

  typedef struct {
    bit          do_wr;
    logic [31:0] wa;
    logic [31:0] wd;
    logic [31:0] ra;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.Addr      = a;
    bus.WriteData = d;
    bus.MemWrite  = 1'b1;
    @(negedge clk);
    bus.MemWrite  = 1'b0;
  endtask

  task automatic rd(input string name, input logic [31:0] a, input logic [31:0] exp);
    bus.Addr    = a;
    bus.MemRead = 1'b1;
    rd_q.push_back(exp);
    @(negedge clk);
    bus.MemRead = 1'b0;
    check(name, bus.ReadData, rd_q.pop_front());
  endtask

  task automatic exp_frame(input logic [7:0] b, input int p);
    logic v;
    for (int k = 0; k < 10; k++) begin
      if (k == 0)      v = 1'b0;
      else if (k == 9) v = 1'b1;
      else             v = b[k-1];
      for (int c = 0; c < p; c++) tx_q.push_back(v);
    end
  endtask

  task automatic exp_idle(input int n);
    for (int c = 0; c < n; c++) tx_q.push_back(1'b1);
  endtask

  // Consumes the whole expected tx queue, one sample per cycle; optionally
  // issues a TXDATA store in the first of those cycles.
  task automatic run_tx(input string name, input bit do_push, input logic [7:0] b, input bit irq_low);
    int n;
    n = tx_q.size();
    if (do_push) begin
      bus.Addr      = A_TX;
      bus.WriteData = {24'd0, b};
      bus.MemWrite  = 1'b1;
    end
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i == 0) bus.MemWrite = 1'b0;
      check($sformatf("%s tx[%0d]", name, i), 32'(tx), 32'(tx_q.pop_front()));
      if (irq_low) check($sformatf("%s irq[%0d]", name, i), 32'(irq), 32'd0);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.MemWrite  = 1'b0;
    bus.MemRead   = 1'b0;
    bus.Addr      = '0;
    bus.WriteData = '0;
    bus.funct3    = 3'b010;

    vecs[0]  = '{1'b0, 32'h0,          32'h0,          A_ST,           32'h2};
    vecs[1]  = '{1'b0, 32'h0,          32'h0,          A_DIV,          32'd868};
    vecs[2]  = '{1'b0, 32'h0,          32'h0,          A_CTRL,         32'h0};
    vecs[3]  = '{1'b0, 32'h0,          32'h0,          A_TX,           32'h0};
    vecs[4]  = '{1'b1, A_ST,           32'hFFFF_FFFF,  A_ST,           32'h2};
    vecs[5]  = '{1'b1, A_DIV,          32'h0,          A_DIV,          32'h1};
    vecs[6]  = '{1'b1, A_DIV,          32'hABCD_1234,  A_DIV,          32'h1234};
    vecs[7]  = '{1'b1, 32'h2000_0008,  32'h5,          A_DIV,          32'h1234};
    vecs[8]  = '{1'b0, 32'h0,          32'h0,          32'h2000_0008,  32'h0};
    vecs[9]  = '{1'b0, 32'h0,          32'h0,          32'h1000_03F8,  32'h1234};
    vecs[10] = '{1'b1, A_CTRL,         32'hFFFF_FFFF,  A_CTRL,         32'h3};
    vecs[11] = '{1'b1, A_CTRL,         32'h0,          A_CTRL,         32'h0};
    vecs[12] = '{1'b1, 32'h0FFF_FC0C,  32'h1,          A_CTRL,         32'h0};

    // Reset held with store strobes toggling
    for (int i = 0; i < 3; i++) begin
      bus.Addr      = A_TX;
      bus.WriteData = 32'hA0 + 32'(i);
      bus.MemWrite  = ~bus.MemWrite;
      @(negedge clk);
      check($sformatf("reset tx %0d", i), 32'(tx), 32'd1);
      check($sformatf("reset rdata %0d", i), bus.ReadData, 32'd0);
    end
    bus.MemWrite = 1'b0;
    reset        = 1'b1;

    // Register vectors
    for (int i = 0; i < 13; i++) begin
      if (vecs[i].do_wr) wr(vecs[i].wa, vecs[i].wd);
      rd($sformatf("vec%0d", i), vecs[i].ra, vecs[i].exp);
    end

    // Single frame, period 4
    wr(A_DIV, 32'd4);
    wr(A_CTRL, 32'd1);
    exp_frame(8'h55, 4);
    wr(A_TX, 32'h55);
    run_tx("single", 1'b0, 8'h00, 1'b0);
    rd("busy last stop cycle", A_ST, 32'h6);
    rd("busy dropped", A_ST, 32'h2);

    // Back-to-back frames, period 2
    wr(A_DIV, 32'd2);
    exp_frame(8'h00, 2);
    exp_frame(8'hFF, 2);
    wr(A_TX, 32'h00);
    run_tx("b2b", 1'b1, 8'hFF, 1'b0);
    @(negedge clk);

    // Mid-frame DIV change and disable
    wr(A_DIV, 32'd3);
    wr(A_CTRL, 32'd0);
    wr(A_TX, 32'hA5);
    wr(A_TX, 32'h3C);
    rd("mid queued", A_ST, 32'h200);
    exp_frame(8'hA5, 3);
    exp_idle(10);
    wr(A_CTRL, 32'd1);
    fork
      run_tx("mid f1", 1'b0, 8'h00, 1'b0);
      begin
        repeat (5) @(negedge clk);
        wr(A_DIV, 32'd8);
        wr(A_CTRL, 32'd0);
      end
    join
    rd("mid held", A_ST, 32'h100);
    rd("mid div", A_DIV, 32'd8);
    exp_frame(8'h3C, 8);
    wr(A_CTRL, 32'd1);
    run_tx("mid f2", 1'b0, 8'h00, 1'b0);

    // Interrupt
    wr(A_CTRL, 32'd3);
    check("irq before en", 32'(irq), 32'd0);
    @(negedge clk);
    check("irq asserted", 32'(irq), 32'd1);
    wr(A_DIV, 32'd2);
    exp_frame(8'h96, 2);
    wr(A_TX, 32'h96);
    check("irq lag", 32'(irq), 32'd1);
    run_tx("irq", 1'b0, 8'h00, 1'b1);
    @(negedge clk);
    check("irq after stop", 32'(irq), 32'd0);
    @(negedge clk);
    check("irq reassert", 32'(irq), 32'd1);

    // Overflow and W1C
    wr(A_CTRL, 32'd0);
    for (int i = 0; i < 17; i++) wr(A_TX, 32'(i));
    rd("ovf status", A_ST, 32'h1009);
    wr(A_ST, 32'h8);
    rd("ovf cleared", A_ST, 32'h1001);

    // Push into a full FIFO in the same cycle as a pop
    wr(A_DIV, 32'd2);
    wr(A_CTRL, 32'd1);
    wr(A_TX, 32'hEE);
    rd("full push+pop", A_ST, 32'h1005);
    check("tx low mid-frame", 32'(tx), 32'd0);

    // Asynchronous reset mid-frame
    #2 reset = 1'b0;
    #1 check("async reset tx", 32'(tx), 32'd1);
    check("async reset rdata", bus.ReadData, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    rd("post reset status", A_ST, 32'h2);
    rd("post reset div", A_DIV, 32'd868);
    rd("post reset ctrl", A_CTRL, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

`default_nettype wire
